// File: rtl/conv_engine_pkg.sv
// Shared definitions for the expand-layer convolution engine.
// Contents: FSM state encodings, derived-size helpers, and the requantise/saturate function.
// Sizing:   the helpers are constant functions used to size top-level ports.
package conv_engine_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int calc_taps(input int kdim, input int chin);
    return kdim * kdim * chin;
  endfunction

  function automatic int calc_groups(input int chout, input int dsp_no);
    return chout / dsp_no;
  endfunction

  function automatic int calc_acc_w(input int width, input int taps);
    return 2 * width + $clog2(taps);
  endfunction

  // Index widths never collapse to zero, even when a dimension is 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round half up, arithmetic shift, optional ReLU, then clamp to a signed
  // WIDTH range. Computed in 64 bits so that any legal ACC_W fits.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] sum,
                                                   input int frac_shift,
                                                   input int width,
                                                   input bit relu_en);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = (sum + (64'sd1 <<< (frac_shift - 1))) >>> frac_shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (relu_en && (v < 64'sd0)) v = 64'sd0;
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_expand_engine_mac_lane.sv
// One MAC lane: S1 operand register, S2 load-or-accumulate, requantised output register.
// Latency: output register updates 3 cycles after the final tap of a window is accepted.
// Backpressure: none; i_beat / i_s1_vld gaps simply hold the operand and accumulator state.
// Ports: i_clk, i_rst_n (async active-low); i_beat captures i_ifm/i_w; i_s1_vld with
//        i_s1_first loads or accumulates; i_fire latches requantised acc + i_bias into o_ofm.
module mac_lane
  import conv_engine_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ACC_W      = 36,
  parameter int FRAC_SHIFT = 8,
  parameter int RELU_EN    = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_beat,
  input  logic             i_s1_vld,
  input  logic             i_s1_first,
  input  logic             i_fire,
  input  logic [WIDTH-1:0] i_ifm,
  input  logic [WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0] i_bias,
  output logic [WIDTH-1:0] o_ofm
);

  logic signed [WIDTH-1:0]   r_ifm;
  logic signed [WIDTH-1:0]   r_w;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [WIDTH-1:0]   r_ofm;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [63:0]        w_sum;

  assign w_prod     = r_ifm * r_w;
  assign w_prod_ext = ACC_W'(w_prod);
  // Bias is aligned to the accumulator's fixed-point scale before rounding.
  assign w_sum      = 64'(r_acc) + (64'($signed(i_bias)) <<< FRAC_SHIFT);
  assign o_ofm      = r_ofm;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ifm <= '0;
      r_w   <= '0;
      r_acc <= '0;
      r_ofm <= '0;
    end else begin
      if (i_beat) begin
        r_ifm <= i_ifm;
        r_w   <= i_w;
      end
      // Tap 0 overwrites, so consecutive windows need no clear cycle.
      if (i_s1_vld) r_acc <= i_s1_first ? w_prod_ext : r_acc + w_prod_ext;
      if (i_fire)   r_ofm <= WIDTH'(sat_round(w_sum, FRAC_SHIFT, WIDTH, RELU_EN != 0));
    end
  end

endmodule

// File: rtl/conv_expand_engine.sv
// Expand-layer convolution engine: DSP_NO parallel MAC lanes over a pre-windowed tap stream.
// Latency: ofm_valid 3 cycles after a window's final tap; done coincides with the last ofm_valid.
// Backpressure: ifm_valid/ifm_ready input handshake; no output backpressure.
// Ports: clk, rst (async active-low); start/busy/done control; ifm/ifm_valid/ifm_ready input;
//        w_addr/w_data and bias_sel/bias_data combinational ROM lookups; ofm/ofm_valid/ofm_grp out.
module conv_expand_engine
  import conv_engine_pkg::*;
#(
  parameter int DSP_NO      = 64,
  parameter int WIDTH       = 16,
  parameter int CHIN        = 16,
  parameter int KERNEL_DIM  = 3,
  parameter int W_IN        = 64,
  parameter int H_IN        = 64,
  parameter int CHOUT       = 64,
  parameter int FRAC_SHIFT  = 8,
  parameter int RELU_EN     = 1,
  localparam int TAPS       = calc_taps(KERNEL_DIM, CHIN),
  localparam int GROUPS     = calc_groups(CHOUT, DSP_NO),
  localparam int ACC_W      = calc_acc_w(WIDTH, TAPS),
  localparam int ADDR_W     = clog2_min1(GROUPS * TAPS),
  localparam int GRP_W      = clog2_min1(GROUPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [WIDTH-1:0]        ifm,
  input  logic                    ifm_valid,
  output logic                    ifm_ready,
  output logic [ADDR_W-1:0]       w_addr,
  input  logic [DSP_NO*WIDTH-1:0] w_data,
  output logic [GRP_W-1:0]        bias_sel,
  input  logic [DSP_NO*WIDTH-1:0] bias_data,
  output logic [DSP_NO*WIDTH-1:0] ofm,
  output logic                    ofm_valid,
  output logic [GRP_W-1:0]        ofm_grp
);

  localparam int NPIX  = W_IN * H_IN;
  localparam int TAP_W = clog2_min1(TAPS);
  localparam int PIX_W = clog2_min1(NPIX);

  logic [1:0]       r_state;
  logic [TAP_W-1:0] r_tap;
  logic [GRP_W-1:0] r_grp;
  logic [PIX_W-1:0] r_pix;
  logic             r_done;
  logic             r_s1_vld, r_s1_first, r_s1_last, r_s1_end;
  logic [GRP_W-1:0] r_s1_grp;
  logic             r_s2_fire, r_s2_end;
  logic [GRP_W-1:0] r_bias_sel;
  logic             r_ofm_valid;
  logic [GRP_W-1:0] r_ofm_grp;
  logic             w_beat, w_last_tap, w_last_grp, w_last_pix, w_final;

  assign w_beat     = ifm_valid && (r_state == ST_RUN);
  assign w_last_tap = (r_tap == TAP_W'(TAPS - 1));
  assign w_last_grp = (r_grp == GRP_W'(GROUPS - 1));
  assign w_last_pix = (r_pix == PIX_W'(NPIX - 1));
  assign w_final    = w_beat && w_last_tap && w_last_grp && w_last_pix;

  assign busy      = (r_state != ST_IDLE);
  assign ifm_ready = (r_state == ST_RUN);
  assign done      = r_done;
  assign w_addr    = ADDR_W'(r_grp) * ADDR_W'(TAPS) + ADDR_W'(r_tap);
  assign bias_sel  = r_bias_sel;
  assign ofm_valid = r_ofm_valid;
  assign ofm_grp   = r_ofm_grp;

  // FSM and tap/group/pixel counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_tap   <= '0;
      r_grp   <= '0;
      r_pix   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state <= ST_RUN;
          r_tap   <= '0;
          r_grp   <= '0;
          r_pix   <= '0;
        end
        ST_RUN:   if (w_final) r_state <= ST_DRAIN;
        // r_s2_end reaches here one cycle before the last output register loads.
        ST_DRAIN: if (r_s2_end) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
        default:  r_state <= ST_IDLE;
      endcase
      if (w_beat) begin
        if (w_last_tap) begin
          r_tap <= '0;
          if (w_last_grp) begin
            r_grp <= '0;
            r_pix <= w_last_pix ? '0 : r_pix + 1'b1;
          end else begin
            r_grp <= r_grp + 1'b1;
          end
        end else begin
          r_tap <= r_tap + 1'b1;
        end
      end
    end
  end

  // Control flags travel alongside the lane data so bubbles never corrupt a window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_end    <= 1'b0;
      r_s1_grp    <= '0;
      r_s2_fire   <= 1'b0;
      r_s2_end    <= 1'b0;
      r_bias_sel  <= '0;
      r_ofm_valid <= 1'b0;
      r_ofm_grp   <= '0;
    end else begin
      r_s1_vld <= w_beat;
      if (w_beat) begin
        r_s1_first <= (r_tap == '0);
        r_s1_last  <= w_last_tap;
        r_s1_end   <= w_final;
        r_s1_grp   <= r_grp;
      end
      r_s2_fire <= r_s1_vld && r_s1_last;
      r_s2_end  <= r_s1_vld && r_s1_end;
      // bias_sel holds the completing window's group while requant samples bias_data.
      if (r_s1_vld && r_s1_last) r_bias_sel <= r_s1_grp;
      r_ofm_valid <= r_s2_fire;
      if (r_s2_fire) r_ofm_grp <= r_bias_sel;
    end
  end

  for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
    mac_lane #(
      .WIDTH      (WIDTH),
      .ACC_W      (ACC_W),
      .FRAC_SHIFT (FRAC_SHIFT),
      .RELU_EN    (RELU_EN)
    ) u_lane (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .i_beat     (w_beat),
      .i_s1_vld   (r_s1_vld),
      .i_s1_first (r_s1_first),
      .i_fire     (r_s2_fire),
      .i_ifm      (ifm),
      .i_w        (w_data[g*WIDTH +: WIDTH]),
      .i_bias     (bias_data[g*WIDTH +: WIDTH]),
      .o_ofm      (ofm[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/conv_expand_engine.md
# conv_expand_engine

Parametrised convolution engine for the fire-module expand layers: streams a pre-windowed input-feature-map sequence through `DSP_NO` parallel MAC lanes, adds per-channel bias, requantises with rounding, applies optional ReLU with saturation, and emits one `DSP_NO`-wide output vector per window per channel group. It supersedes the fixed-size expand blocks:
- 1×1 and 3×3 kernels, any `CHIN`/`CHOUT`, and `CHOUT > DSP_NO` through channel-group time multiplexing.
- Start/busy/done control, an input valid/ready handshake and an output valid strobe, with no derived clocks.

## Interface
- `DSP_NO`, 64: parallel MAC lanes (output channels per group).
- `WIDTH`, 16: signed fixed-point width of ifm, weights, bias and ofm.
- `CHIN`, 16: input channels.
- `KERNEL_DIM`, 3: kernel side (1 or 3).
- `W_IN`, 64: feature-map width.
- `H_IN`, 64: feature-map height.
- `CHOUT`, 64: output channels; must be a multiple of `DSP_NO`.
- `FRAC_SHIFT`, 8: requantisation right shift, ≥1.
- `RELU_EN`, 1: 1 clamps negatives to 0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a layer; ignored while `busy`.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse when the layer completes.
- `ifm` in `WIDTH`: input pixel, one tap per beat.
- `ifm_valid` in 1: `ifm` is valid.
- `ifm_ready` out 1: engine accepts `ifm` this cycle.
- `w_addr` out clog2(`GROUPS`·`TAPS`): weight ROM address, equal to grp·`TAPS` + tap.
- `w_data` in `DSP_NO`×`WIDTH`: combinational ROM data for `w_addr`.
- `bias_sel` out clog2(`GROUPS`) (min 1): current channel group.
- `bias_data` in `DSP_NO`×`WIDTH`: combinational bias for `bias_sel`.
- `ofm` out `DSP_NO`×`WIDTH`: output vector.
- `ofm_valid` out 1: one-cycle strobe for `ofm`.
- `ofm_grp` out clog2(`GROUPS`): group of the current `ofm`.

Derived values: `TAPS` = `KERNEL_DIM`²·`CHIN`; `GROUPS` = `CHOUT`/`DSP_NO`; `ACC_W` = 2·`WIDTH` + clog2(`TAPS`).

## Operation
State machine:
- IDLE → RUN on `start`; all counters cleared.
- RUN → DRAIN when the final tap of the final group of the final pixel is accepted.
- DRAIN → IDLE once the last `ofm_valid` has issued. `done` pulses in that same cycle.

Counters:
- Nesting, innermost first: `tap` 0..`TAPS`-1, then `grp` 0..`GROUPS`-1, then `pix` 0..`W_IN`·`H_IN`-1.
- Each counter advances only on an accepted beat (`ifm_valid` && `ifm_ready`) and wraps to 0 when it reaches its maximum.
- Upstream replays each window once per group, in tap order, with zero padding already inserted.

Handshake:
- `ifm_ready` = 1 in RUN, 0 otherwise. There is no output backpressure.
- `ifm_valid` low stalls the tap counter and the pipeline. Accumulators hold their value.

Datapath, per lane:
- Stage S1 registers `ifm` and `w_data[lane]` on each accepted beat.
- Stage S2 accumulates the signed product. Tap 0 loads the product instead of adding it, so there is no clear bubble between windows.
- `ACC_W` guarantees no accumulator overflow.

Requantisation, on the final tap:
- sum = acc + (sign-extended bias << `FRAC_SHIFT`).
- Add 2^(`FRAC_SHIFT`-1), then arithmetic-shift right by `FRAC_SHIFT`.
- If `RELU_EN`, negatives become 0.
- Saturate to [−2^(`WIDTH`-1), 2^(`WIDTH`-1)−1].

Bias lookup:
- `bias_sel` is captured with the group of the final tap, so `bias_data` is sampled for the window that is completing.

## Timing
- Reset: state IDLE; `busy`, `done`, `ofm_valid`, `ifm_ready` all 0; `ofm` all 0; `ofm_grp`, `w_addr`, `bias_sel` all 0; all counters 0.
- Latency: `ofm_valid` asserts 3 cycles after the final tap of a window is accepted (S1, S2, requant register).
- Throughput with `ifm_valid` held high:
  - one `ofm` vector every `TAPS` cycles;
  - the layer completes in `W_IN`·`H_IN`·`GROUPS`·`TAPS` + 3 cycles after `busy` rises.
- `w_addr` tracks the current tap and group combinationally from the counters, so `w_data` aligns with the beat being accepted.
- `start` while `busy` has no effect.
- `rst` asserted mid-layer returns the engine to IDLE immediately with reset values. Partial sums are discarded and `done` is not issued.
- `done` and the final `ofm_valid` coincide.

## Structure
- Package `conv_engine_pkg`: the `TAPS`, `GROUPS` and `ACC_W` derivation functions, the state enum (IDLE/RUN/DRAIN), and a `sat_round` function.
- One sub-module, `mac_lane`, holds S1/S2, the load-or-accumulate logic and requantisation for one lane. It is instantiated `DSP_NO` times.
- Top level holds the FSM, the counters and the address generation.

## Test plan
1. `DSP_NO`=2, `CHIN`=1, `KERNEL_DIM`=1, `W_IN`=`H_IN`=2, `CHOUT`=2; ifm 256 (1.0), weights 512/−256, bias 0 → `ofm` = {512, 0} for each of 4 pixels; `done` at cycle 7 after `busy`.
2. Same configuration with `RELU_EN`=0 and weight −256 → lane 1 outputs −256. Products of 32767·32767 → saturated to 32767.
3. `CHOUT`=4, `DSP_NO`=2 → `ofm_grp` alternates 0,1 per pixel and `w_addr` steps 0..2·`TAPS`−1.
4. Rounding: acc = 0x0180, `FRAC_SHIFT`=8 → 2; acc = 0x017F → 1.
5. Random `ifm_valid` gaps (50% duty) → outputs bit-identical to the gap-free run and `ofm_valid` count = `W_IN`·`H_IN`·`GROUPS`.
6. `rst` pulled low mid-window, then `start` reissued → no stale `ofm_valid`; the full layer reproduces reference results.
